fpu_mul_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `fpu_mul` instance among `N_REQ` requesters. It accepts operand pairs on per-requester valid/ready ports and drives the multiplier's `input_a` / `input_b` / `output_z` strobe/ack handshake in the order the multiplier requires. It returns each product on a single tagged response channel. It sits between requester logic and `fpu_mul`, and shares `clk`/`rst` with it.

---
 rtl/fpu_mul_arb_pkg.sv | 26 ++
 rtl/fpu_mul_arb_rr_pick.sv | 46 ++++
 rtl/fpu_mul_arb.sv | 149 ++++++++++++++
 tb/tb_fpu_mul_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_arb_pkg.sv
// Shared types and constants for the fpu_mul round-robin arbiter/sequencer.
package fpu_mul_arb_pkg;

   localparam int LAT_W = 16;
   localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_A = 3'd1,
      SEND_B = 3'd2,
      WAIT_Z = 3'd3,
      RESP   = 3'd4
   } arb_state_e;

   // Latency counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
      logic [LAT_W-1:0] r;
      if (v == {LAT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + LAT_ONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/fpu_mul_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping to 0.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]  grant_idx
);

   logic             found_s;
   logic [ID_W-1:0]  idx_s;

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N_REQ) begin
         s = s - N_REQ;
      end else begin
         s = s;
      end
      return ID_W'(s);
   endfunction

   // Scan offsets 0..N_REQ-1 from ptr and keep the first valid hit.
   always_comb begin
      found_s      = 1'b0;
      idx_s        = '0;
      grant_idx    = '0;
      grant_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_s = wrap_idx(ptr, k);
         if (!found_s && valid[idx_s]) begin
            found_s   = 1'b1;
            grant_idx = idx_s;
         end else begin
            found_s   = found_s;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         grant_onehot[i] = found_s && (grant_idx == ID_W'(i));
      end
   end

endmodule

// File: rtl/fpu_mul_arb.sv
// Shares one fpu_mul among N_REQ requesters: round-robin grant, a/b/z handshake sequencing,
// tagged response with backpressure, and a saturating per-op latency report.
module fpu_mul_arb
   import fpu_mul_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_z,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   output logic                   mul_a_stb,
   output logic                   mul_b_stb,
   input  logic                   mul_a_ack,
   input  logic                   mul_b_ack,
   input  logic [WIDTH-1:0]       mul_z,
   input  logic                   mul_z_stb,
   output logic                   mul_z_ack,
   output logic [LAT_W-1:0]       last_lat
);

   arb_state_e        state_r;
   logic [ID_W-1:0]   ptr_r;
   logic [ID_W-1:0]   id_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [WIDTH-1:0]  z_r;
   logic [LAT_W-1:0]  lat_cnt_r;
   logic [LAT_W-1:0]  last_lat_r;
   logic              a_stb_r;
   logic              b_stb_r;
   logic              z_ack_r;
   logic              rsp_valid_r;
   logic [N_REQ-1:0]  grant_onehot_s;
   logic [ID_W-1:0]   grant_idx_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .valid        (req_valid),
      .ptr          (ptr_r),
      .grant_onehot (grant_onehot_s),
      .grant_idx    (grant_idx_s)
   );

   // The accept pulse is the only combinational output; it is offered only while idle.
   always_comb begin
      if ((state_r == IDLE) && !rst) begin
         req_ready = grant_onehot_s;
      end else begin
         req_ready = '0;
      end
   end

   // Sequencer FSM; strobes/acks are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         id_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         z_r         <= '0;
         lat_cnt_r   <= '0;
         last_lat_r  <= '0;
         a_stb_r     <= 1'b0;
         b_stb_r     <= 1'b0;
         z_ack_r     <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (|req_valid) begin
                  a_r       <= req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
                  b_r       <= req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
                  id_r      <= grant_idx_s;
                  lat_cnt_r <= LAT_ONE;
                  a_stb_r   <= 1'b1;
                  state_r   <= SEND_A;
               end
            end
            SEND_A: begin
               lat_cnt_r <= lat_sat_inc(lat_cnt_r);
               if (a_stb_r && mul_a_ack) begin
                  a_stb_r <= 1'b0;
                  b_stb_r <= 1'b1;
                  state_r <= SEND_B;
               end
            end
            SEND_B: begin
               lat_cnt_r <= lat_sat_inc(lat_cnt_r);
               if (mul_b_ack) begin
                  b_stb_r <= 1'b0;
                  z_ack_r <= 1'b1;
                  state_r <= WAIT_Z;
               end
            end
            WAIT_Z: begin
               // The capture cycle itself is already included in lat_cnt_r.
               if (mul_z_stb) begin
                  z_r         <= mul_z;
                  last_lat_r  <= lat_cnt_r;
                  z_ack_r     <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end else begin
                  lat_cnt_r <= lat_sat_inc(lat_cnt_r);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  ptr_r       <= (id_r == ID_W'(N_REQ-1)) ? '0 : id_r + {{(ID_W-1){1'b0}}, 1'b1};
                  state_r     <= IDLE;
               end
            end
            default: begin
               a_stb_r     <= 1'b0;
               b_stb_r     <= 1'b0;
               z_ack_r     <= 1'b0;
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign mul_a     = a_r;
   assign mul_b     = b_r;
   assign mul_a_stb = a_stb_r;
   assign mul_b_stb = b_stb_r;
   assign mul_z_ack = z_ack_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = id_r;
   assign rsp_z     = z_r;
   assign last_lat  = last_lat_r;

endmodule

// File: tb/tb_fpu_mul_arb.sv
// Bench for fpu_mul_arb: directed scenarios plus random traffic against a requester/scoreboard
// model and a stand-in multiplier with programmable result delay.
module tb_fpu_mul_arb;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic [IW-1:0]  rsp_id;
   logic [W-1:0]   rsp_z;
   logic           rsp_ready;
   logic [W-1:0]   mul_a, mul_b, mul_z;
   logic           mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
   logic [15:0]    last_lat;

   logic [N-1:0]   pend;
   logic [W-1:0]   op_a [N];
   logic [W-1:0]   op_b [N];
   logic           a_ack_en, b_ack_en;
   int             m_delay, m_cnt, m_del_used;
   logic [W-1:0]   m_a, m_b;

   int             n_checks, n_pass;
   bit             busy, in_resp, retire_v, rand_mode, use_const;
   int             retire_id, cur_id, ptr_m, na, nb;
   logic [W-1:0]   cur_a, cur_b, const_z;
   int             wait_ops [N];
   int             grant_log [$];

   always #5 clk = ~clk;

   fpu_mul_arb #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
      .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .last_lat(last_lat)
   );

   always_comb begin
      req_valid = pend;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
      end
   end

   assign mul_a_ack = mul_a_stb & a_ack_en;
   assign mul_b_ack = mul_b_stb & b_ack_en;

   // Single-precision multiply for normal operands, truncating; stands in for fpu_mul.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
      else       return {a[31] ^ b[31], e[7:0], p[45:23]};
   endfunction

   function automatic logic [31:0] rand_float();
      return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   function automatic int pick(input int p, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int log_at(input int k);
      if (k < grant_log.size()) return grant_log[k];
      return -1;
   endfunction

   // Stand-in multiplier: takes a then b, raises z m_delay cycles after the b handshake.
   always @(posedge clk) begin
      if (rst) begin
         mul_z_stb <= 1'b0;
         mul_z     <= '0;
         m_cnt     <= 0;
      end else begin
         if (mul_a_stb && mul_a_ack) m_a <= mul_a;
         if (mul_b_stb && mul_b_ack) begin
            m_b        <= mul_b;
            m_cnt      <= m_delay - 1;
            m_del_used <= m_delay;
         end else if (m_cnt == 1) begin
            m_cnt     <= 0;
            mul_z_stb <= 1'b1;
            mul_z     <= fmul(m_a, m_b);
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end
         if (mul_z_stb && mul_z_ack) mul_z_stb <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic randomize_inputs();
      a_ack_en  = ($urandom_range(0, 3) != 0);
      b_ack_en  = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      m_delay   = $urandom_range(2, 6);
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1; op_a[i] = rand_float(); op_b[i] = rand_float(); wait_ops[i] = 0;
         end else if (pend[i] && $urandom_range(0, 31) == 0) begin
            pend[i] = 1'b0; wait_ops[i] = 0;
         end
      end
   endtask

   // One cycle: drive, observe at negedge+1 against the model, then retire the granted request.
   task automatic tick();
      logic [N-1:0] exp_rr;
      int w;
      if (rand_mode) randomize_inputs();
      #1;
      check_eq("ab_excl", 64'(mul_a_stb & mul_b_stb), 64'd0);
      exp_rr = '0;
      w = -1;
      if (!busy && pend != '0) begin
         w = pick(ptr_m, pend);
         exp_rr = N'(1) << w;
      end
      check_eq("req_ready", 64'(req_ready), 64'(exp_rr));
      if (w >= 0) begin
         for (int i = 0; i < N; i++) begin
            if (i != w && pend[i]) begin
               wait_ops[i]++;
               check_eq("fair_wait", 64'(wait_ops[i] < N), 64'd1);
            end
         end
         wait_ops[w] = 0;
         cur_id = w; cur_a = op_a[w]; cur_b = op_b[w];
         busy = 1'b1; in_resp = 1'b0; na = 0; nb = 0;
         retire_v = 1'b1; retire_id = w;
         grant_log.push_back(w);
      end else if (busy) begin
         if (mul_a_stb) begin na++; check_eq("mul_a", 64'(mul_a), 64'(cur_a)); end
         if (mul_b_stb) begin nb++; check_eq("mul_b", 64'(mul_b), 64'(cur_b)); end
         if (rsp_valid) begin
            check_eq("rsp_id", 64'(rsp_id), 64'(cur_id));
            check_eq("rsp_z", 64'(rsp_z), 64'(fmul(cur_a, cur_b)));
            check_eq("resp_quiet", 64'({mul_a_stb, mul_b_stb, mul_z_ack}), 64'd0);
            if (!in_resp) begin
               in_resp = 1'b1;
               check_eq("last_lat", 64'(last_lat), 64'(m_del_used + na + nb));
               if (use_const) check_eq("dir_z", 64'(rsp_z), 64'(const_z));
            end
            if (rsp_ready) begin
               busy = 1'b0;
               ptr_m = (cur_id + 1) % N;
            end
         end else if (in_resp) begin
            check_eq("rsp_hold", 64'(rsp_valid), 64'd1);
         end
      end else begin
         check_eq("rsp_idle", 64'(rsp_valid), 64'd0);
      end
      @(negedge clk);
      if (retire_v) begin
         pend[retire_id] = 1'b0;
         retire_v = 1'b0;
      end
   endtask

   task automatic run_until_idle(input int budget);
      int c;
      c = 0;
      while ((busy || pend != '0) && c < budget) begin
         tick();
         c++;
      end
      check_eq("drain", 64'({busy, pend}), 64'd0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      pend = '0;
      retire_v = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      busy = 1'b0; in_resp = 1'b0; ptr_m = 0;
      for (int i = 0; i < N; i++) wait_ops[i] = 0;
      #1;
      check_eq("rst_ctrl", 64'({req_ready, rsp_valid, mul_a_stb, mul_b_stb, mul_z_ack}), 64'd0);
      check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
      check_eq("rst_rsp_z", 64'(rsp_z), 64'd0);
      check_eq("rst_mul_a", 64'(mul_a), 64'd0);
      check_eq("rst_mul_b", 64'(mul_b), 64'd0);
      check_eq("rst_last_lat", 64'(last_lat), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int n0;
      n_checks = 0; n_pass = 0;
      rst = 1'b1; pend = '0; rsp_ready = 1'b1; a_ack_en = 1'b1; b_ack_en = 1'b1;
      m_delay = 3; m_del_used = 0; rand_mode = 1'b0; use_const = 1'b0; const_z = '0;
      busy = 1'b0; in_resp = 1'b0; retire_v = 1'b0; ptr_m = 0; cur_id = 0;
      for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; wait_ops[i] = 0; end
      @(negedge clk);
      do_reset(2);

      // 2.0 x 3.0 from requester 2
      grant_log.delete();
      op_a[2] = 32'h40000000; op_b[2] = 32'h40400000; pend[2] = 1'b1;
      use_const = 1'b1; const_z = 32'h40C00000;
      run_until_idle(60);
      use_const = 1'b0;
      check_eq("single_n", 64'(grant_log.size()), 64'd1);
      check_eq("single_id", 64'(log_at(0)), 64'd2);

      // Grant id 3, then 1 and 3 together must wrap to 1 first
      op_a[3] = rand_float(); op_b[3] = rand_float(); pend[3] = 1'b1;
      run_until_idle(60);
      grant_log.delete();
      op_a[1] = rand_float(); op_b[1] = rand_float(); pend[1] = 1'b1;
      op_a[3] = rand_float(); op_b[3] = rand_float(); pend[3] = 1'b1;
      run_until_idle(100);
      check_eq("wrap_first", 64'(log_at(0)), 64'd1);
      check_eq("wrap_second", 64'(log_at(1)), 64'd3);

      // All four at once, 1.5 x 1.5
      grant_log.delete();
      for (int i = 0; i < N; i++) begin op_a[i] = 32'h3FC00000; op_b[i] = 32'h3FC00000; end
      pend = '1; use_const = 1'b1; const_z = 32'h40100000;
      run_until_idle(200);
      use_const = 1'b0;
      check_eq("all4_n", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < N; i++) check_eq("all4_order", 64'(log_at(i)), 64'(i));

      // Response backpressure with requester 0 still asking
      rsp_ready = 1'b0;
      op_a[0] = rand_float(); op_b[0] = rand_float(); pend[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (rsp_valid) break;
         tick();
      end
      check_eq("bp_rsp_seen", 64'(rsp_valid), 64'd1);
      n0 = grant_log.size();
      op_a[0] = rand_float(); op_b[0] = rand_float(); pend[0] = 1'b1;
      repeat (10) tick();
      check_eq("bp_no_grant", 64'(grant_log.size()), 64'(n0));
      check_eq("bp_rsp_held", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      run_until_idle(80);
      check_eq("bp_second", 64'(grant_log.size()), 64'(n0 + 1));

      // Multiplier answers 7 cycles after b_ack, single-cycle a/b handshakes
      m_delay = 7;
      op_a[1] = rand_float(); op_b[1] = rand_float(); pend[1] = 1'b1;
      run_until_idle(60);
      check_eq("lat_7", 64'(last_lat), 64'd9);

      // Reset while waiting for the product
      m_delay = 20;
      op_a[2] = rand_float(); op_b[2] = rand_float(); pend[2] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (mul_z_ack) break;
         tick();
      end
      check_eq("rm_in_wait", 64'(mul_z_ack), 64'd1);
      do_reset(1);
      grant_log.delete();
      m_delay = 3;
      op_a[1] = rand_float(); op_b[1] = rand_float(); pend[1] = 1'b1;
      op_a[3] = rand_float(); op_b[3] = rand_float(); pend[3] = 1'b1;
      run_until_idle(100);
      check_eq("rm_first", 64'(log_at(0)), 64'd1);
      check_eq("rm_second", 64'(log_at(1)), 64'd3);

      // Random traffic, random handshake and response stalls
      rand_mode = 1'b1;
      repeat (600) tick();
      rand_mode = 1'b0;
      rsp_ready = 1'b1; a_ack_en = 1'b1; b_ack_en = 1'b1;
      run_until_idle(300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
